// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with 2-flop synchronizer and mid-bit sampling.
// Optional even parity (8E1) with parity_error output when UART_RX_PARITY_EN is defined.
module uart_receiver #(
   parameter int CLK_FREQUENCY = 100_000_000,
   parameter int BAUD_RATE     = 19_200
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx_in,
   output logic [7:0] dout,
   output logic       data_strobe,
   output logic       busy,
`ifdef UART_RX_PARITY_EN
   output logic       parity_error,
`endif
   output logic       frame_error
);
   localparam int BAUD_CLOCKS = CLK_FREQUENCY / BAUD_RATE;
   localparam int HALF_CLOCKS = BAUD_CLOCKS / 2;
   localparam int TW = $clog2(BAUD_CLOCKS);
   localparam logic [TW-1:0] BAUD_END = TW'(BAUD_CLOCKS - 1);
   localparam logic [TW-1:0] HALF_END = TW'(HALF_CLOCKS - 1);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd4;
`endif

   logic [1:0]    sync_q;
   logic          prev_q;
   logic          rx_s;
   logic [2:0]    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    dout_q, dout_d;
   logic          fe_q, fe_d;
   logic          strobe_q, strobe_d;
`ifdef UART_RX_PARITY_EN
   logic          par_q, par_d;
   logic          pe_q, pe_d;
   assign parity_error = pe_q;
`endif

   assign rx_s        = sync_q[1];
   assign dout        = dout_q;
   assign frame_error = fe_q;
   assign data_strobe = strobe_q;
   assign busy        = state_q != IDLE;

   // Synchronize the line and keep one cycle of history for start-edge detection.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_q <= 2'b11;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], rx_in};
         prev_q <= rx_s;
      end
   end

   // Frame FSM: half-bit start check, then one sample per bit period; timer restarts at every sample.
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q + 1'b1;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      dout_d   = dout_q;
      fe_d     = fe_q;
      strobe_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d    = par_q;
      pe_d     = pe_q;
`endif
      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (prev_q && !rx_s) state_d = START;
         end
         START: if (timer_q == HALF_END) begin
            timer_d = '0;
            cnt_d   = '0;
            state_d = rx_s ? IDLE : DATA;
         end
         DATA: if (timer_q == BAUD_END) begin
            timer_d = '0;
            shift_d = {rx_s, shift_q[7:1]};
            cnt_d   = cnt_q + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (cnt_q == 3'd7) state_d = PARITY;
`else
            if (cnt_q == 3'd7) state_d = STOP;
`endif
         end
`ifdef UART_RX_PARITY_EN
         PARITY: if (timer_q == BAUD_END) begin
            timer_d = '0;
            par_d   = rx_s;
            state_d = STOP;
         end
`endif
         STOP: if (timer_q == BAUD_END) begin
            timer_d  = '0;
            dout_d   = shift_q;
            fe_d     = ~rx_s;
            strobe_d = 1'b1;
            state_d  = IDLE;
`ifdef UART_RX_PARITY_EN
            pe_d     = ^{shift_q, par_q};
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset discards any partial frame.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         timer_q  <= '0;
         cnt_q    <= '0;
         shift_q  <= '0;
         dout_q   <= '0;
         fe_q     <= 1'b0;
         strobe_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q    <= 1'b0;
         pe_q     <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         dout_q   <= dout_d;
         fe_q     <= fe_d;
         strobe_q <= strobe_d;
`ifdef UART_RX_PARITY_EN
         par_q    <= par_d;
         pe_q     <= pe_d;
`endif
      end
   end
endmodule
